// File: rtl/ql_dsp_cfg_loader.sv
// ql_dsp_cfg_loader
//   Loads the static mode/coefficient configuration of one DSP tile from a
//   word stream. Words are collected LSB-first in a shadow register and
//   committed to the config outputs in one edge. The tile is held in local
//   reset for HOLD_CYCLES cycles starting at the commit.
//
// Ports
//   clock_i, reset_n_i      clock, async active-low reset
//   cfg_start_i             begin a frame (restarts a frame already in flight)
//   cfg_valid_i/cfg_data_i  word stream, accepted when cfg_ready_o is high
//   cfg_ready_o             high in LOAD
//   busy_o                  high in LOAD and HOLD
//   done_o                  1-cycle pulse when the hold is released
//   err_o                   1-cycle pulse on restart or pad violation
//   dsp_hold_o              local reset to the DSP tile
//   f_mode_o .. coef_3_o    committed configuration fields
module ql_dsp_cfg_loader #(
   parameter int NBITS_A     = 20,
   parameter int WORD_W      = 16,
   parameter int HOLD_CYCLES = 2
) (
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic               cfg_start_i,
   input  logic               cfg_valid_i,
   input  logic [WORD_W-1:0]  cfg_data_i,
   output logic               cfg_ready_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               dsp_hold_o,
   output logic               f_mode_o,
   output logic [2:0]         output_select_o,
   output logic               saturate_enable_o,
   output logic [5:0]         shift_right_o,
   output logic               round_o,
   output logic               subtract_o,
   output logic               register_inputs_o,
   output logic [NBITS_A-1:0] coef_0_o,
   output logic [NBITS_A-1:0] coef_1_o,
   output logic [NBITS_A-1:0] coef_2_o,
   output logic [NBITS_A-1:0] coef_3_o
);

   localparam int CFG_BITS = 14 + 4*NBITS_A;
   localparam int NWORDS   = (CFG_BITS + WORD_W - 1) / WORD_W;
   localparam int FRAME_W  = NWORDS * WORD_W;
   localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int HCNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   // Bits past the config payload in the last word must be zero.
   localparam logic [FRAME_W-1:0] PAD_MASK = {FRAME_W{1'b1}} << CFG_BITS;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  shadow_q, shadow_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [HCNT_W-1:0]   hcnt_q;
   logic [CFG_BITS-1:0] cfg_q;
   logic                hold_q, done_q, err_q;
   logic                accept, last_word, pad_bad, hold_end;

   // A start in LOAD wins over a simultaneous word.
   assign accept    = (state_q == LOAD) && cfg_valid_i && !cfg_start_i;
   assign last_word = accept && (cnt_q == CNT_W'(NWORDS-1));
   assign hold_end  = (hcnt_q == HCNT_W'(HOLD_CYCLES-1));

   // Shadow with the incoming word merged in, so the commit includes the
   // final word in the same edge it is accepted.
   always_comb begin
      shadow_d = shadow_q;
      for (int k = 0; k < NWORDS; k++)
         if (cnt_q == CNT_W'(k)) shadow_d[k*WORD_W +: WORD_W] = cfg_data_i;
   end
   assign pad_bad = |(shadow_d & PAD_MASK);

   // State register
   always_ff @(posedge clock_i or negedge reset_n_i)
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cfg_start_i) state_d = LOAD;
         LOAD: if (!cfg_start_i && last_word) state_d = pad_bad ? IDLE : HOLD;
         HOLD: if (hold_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      cfg_ready_o = (state_q == LOAD);
      busy_o      = (state_q != IDLE);
   end

   // Datapath: shadow, counters, committed config, pulses
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         cfg_q    <= '0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: if (cfg_start_i) begin
               cnt_q    <= '0;
               shadow_q <= '0;
            end
            LOAD: if (cfg_start_i) begin
               err_q    <= 1'b1;
               cnt_q    <= '0;
               shadow_q <= '0;
            end else if (accept) begin
               shadow_q <= shadow_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_word) begin
                  if (pad_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     cfg_q  <= shadow_d[CFG_BITS-1:0];
                     hold_q <= 1'b1;
                     hcnt_q <= '0;
                  end
               end
            end
            HOLD: if (hold_end) begin
               hold_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               hcnt_q <= hcnt_q + HCNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign done_o            = done_q;
   assign err_o             = err_q;
   assign dsp_hold_o        = hold_q;
   assign f_mode_o          = cfg_q[0];
   assign output_select_o   = cfg_q[3:1];
   assign saturate_enable_o = cfg_q[4];
   assign shift_right_o     = cfg_q[10:5];
   assign round_o           = cfg_q[11];
   assign subtract_o        = cfg_q[12];
   assign register_inputs_o = cfg_q[13];
   assign coef_0_o          = cfg_q[14             +: NBITS_A];
   assign coef_1_o          = cfg_q[14 + NBITS_A   +: NBITS_A];
   assign coef_2_o          = cfg_q[14 + 2*NBITS_A +: NBITS_A];
   assign coef_3_o          = cfg_q[14 + 3*NBITS_A +: NBITS_A];

endmodule

// File: tb/tb_ql_dsp_cfg_loader.sv
module tb_ql_dsp_cfg_loader;
   localparam int NA = 20;
   localparam int W  = 16;
   localparam int NW = 6;
   localparam int FW = NW*W;

   logic clock_i = 1'b0;
   logic reset_n_i;
   always #5 clock_i = ~clock_i;

   // Main DUT (HOLD_CYCLES=2)
   logic cfg_start_i = 0, cfg_valid_i = 0;
   logic [W-1:0] cfg_data_i = '0;
   logic cfg_ready_o, busy_o, done_o, err_o, dsp_hold_o;
   logic f_mode_o, saturate_enable_o, round_o, subtract_o, register_inputs_o;
   logic [2:0] output_select_o;
   logic [5:0] shift_right_o;
   logic [NA-1:0] coef_0_o, coef_1_o, coef_2_o, coef_3_o;

   ql_dsp_cfg_loader #(.NBITS_A(NA), .WORD_W(W), .HOLD_CYCLES(2)) dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i),
      .cfg_start_i(cfg_start_i), .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i),
      .cfg_ready_o(cfg_ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .dsp_hold_o(dsp_hold_o), .f_mode_o(f_mode_o), .output_select_o(output_select_o),
      .saturate_enable_o(saturate_enable_o), .shift_right_o(shift_right_o),
      .round_o(round_o), .subtract_o(subtract_o), .register_inputs_o(register_inputs_o),
      .coef_0_o(coef_0_o), .coef_1_o(coef_1_o), .coef_2_o(coef_2_o), .coef_3_o(coef_3_o));

   // Second DUT (HOLD_CYCLES=1)
   logic b_start = 0, b_valid = 0;
   logic [W-1:0] b_data = '0;
   logic b_ready, b_busy, b_done, b_err, b_hold;
   logic b_fm, b_sat, b_rnd, b_sub, b_rgi;
   logic [2:0] b_os;
   logic [5:0] b_sh;
   logic [NA-1:0] b_c0, b_c1, b_c2, b_c3;

   ql_dsp_cfg_loader #(.NBITS_A(NA), .WORD_W(W), .HOLD_CYCLES(1)) dut_h1 (
      .clock_i(clock_i), .reset_n_i(reset_n_i),
      .cfg_start_i(b_start), .cfg_valid_i(b_valid), .cfg_data_i(b_data),
      .cfg_ready_o(b_ready), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
      .dsp_hold_o(b_hold), .f_mode_o(b_fm), .output_select_o(b_os),
      .saturate_enable_o(b_sat), .shift_right_o(b_sh),
      .round_o(b_rnd), .subtract_o(b_sub), .register_inputs_o(b_rgi),
      .coef_0_o(b_c0), .coef_1_o(b_c1), .coef_2_o(b_c2), .coef_3_o(b_c3));

   // exp = {ready, busy, done, err, hold} after the edge
   typedef struct {
      logic         start;
      logic         valid;
      logic [W-1:0] data;
      logic [4:0]   exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic fm, input logic [2:0] os, input logic sat,
                                        input logic [5:0] sh, input logic rnd, input logic sub,
                                        input logic rgi, input logic [NA-1:0] c0, input logic [NA-1:0] c1,
                                        input logic [NA-1:0] c2, input logic [NA-1:0] c3);
      logic [FW-1:0] f;
      f = '0;
      f[0] = fm; f[3:1] = os; f[4] = sat; f[10:5] = sh;
      f[11] = rnd; f[12] = sub; f[13] = rgi;
      f[14 +: NA] = c0; f[34 +: NA] = c1; f[54 +: NA] = c2; f[74 +: NA] = c3;
      return f;
   endfunction

   function automatic logic [4:0] stat();
      return {cfg_ready_o, busy_o, done_o, err_o, dsp_hold_o};
   endfunction

   function automatic logic [4:0] bstat();
      return {b_ready, b_busy, b_done, b_err, b_hold};
   endfunction

   task automatic step(input logic s, input logic v, input logic [W-1:0] d);
      cfg_start_i = s; cfg_valid_i = v; cfg_data_i = d;
      @(posedge clock_i); #1;
      cfg_start_i = 0; cfg_valid_i = 0;
   endtask

   task automatic step_chk(input string name, input logic s, input logic v,
                           input logic [W-1:0] d, input logic [4:0] exp);
      step(s, v, d);
      chk(name, 32'(stat()), 32'(exp));
   endtask

   task automatic bstep_chk(input string name, input logic s, input logic v,
                            input logic [W-1:0] d, input logic [4:0] exp);
      b_start = s; b_valid = v; b_data = d;
      @(posedge clock_i); #1;
      b_start = 0; b_valid = 0;
      chk(name, 32'(bstat()), 32'(exp));
   endtask

   task automatic chk_cfg(input string tag, input logic [FW-1:0] f);
      chk({tag, "_fmode"}, 32'(f_mode_o),          32'(f[0]));
      chk({tag, "_osel"},  32'(output_select_o),   32'(f[3:1]));
      chk({tag, "_sat"},   32'(saturate_enable_o), 32'(f[4]));
      chk({tag, "_shr"},   32'(shift_right_o),     32'(f[10:5]));
      chk({tag, "_rnd"},   32'(round_o),           32'(f[11]));
      chk({tag, "_sub"},   32'(subtract_o),        32'(f[12]));
      chk({tag, "_rgi"},   32'(register_inputs_o), 32'(f[13]));
      chk({tag, "_c0"},    32'(coef_0_o),          32'(f[14 +: NA]));
      chk({tag, "_c1"},    32'(coef_1_o),          32'(f[34 +: NA]));
      chk({tag, "_c2"},    32'(coef_2_o),          32'(f[54 +: NA]));
      chk({tag, "_c3"},    32'(coef_3_o),          32'(f[74 +: NA]));
   endtask

   logic [FW-1:0] fa, fb, fbad, fc, fz;
   vec_t tv [10];

   initial begin
      fa   = mk(1'b1, 3'b101, 1'b0, 6'd17, 1'b0, 1'b0, 1'b0, 20'hABCDE, 20'h0, 20'h0, 20'h12345);
      fb   = mk(1'b0, 3'b000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 20'h0, 20'h00FFF, 20'h0, 20'h0);
      fbad = fb; fbad[95] = 1'b1;
      fc   = mk(1'b0, 3'b010, 1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 20'h11111, 20'h0, 20'h0, 20'h0F0F0);
      fz   = '0;

      // Test 1 vector table
      tv[0] = '{1'b1, 1'b0, 16'h0, 5'b11000};
      for (int k = 0; k < 5; k++) tv[k+1] = '{1'b0, 1'b1, fa[k*W +: W], 5'b11000};
      tv[6] = '{1'b0, 1'b1, fa[5*W +: W], 5'b01001};
      tv[7] = '{1'b0, 1'b0, 16'h0, 5'b01001};
      tv[8] = '{1'b0, 1'b0, 16'h0, 5'b00100};
      tv[9] = '{1'b0, 1'b0, 16'h0, 5'b00000};

      // Reset state
      reset_n_i = 1'b0;
      repeat (2) @(posedge clock_i);
      #1;
      chk("rst_status", 32'(stat()), 32'(0));
      chk_cfg("rst", fz);
      @(negedge clock_i) reset_n_i = 1'b1;
      @(posedge clock_i); #1;

      // Test 1: nominal load
      for (int i = 0; i < 10; i++) begin
         step(tv[i].start, tv[i].valid, tv[i].data);
         chk($sformatf("t1_vec%0d", i), 32'(stat()), 32'(tv[i].exp));
         if (i == 6) chk_cfg("t1_commit", fa);
      end
      chk_cfg("t1_final", fa);

      // Test 5: async reset during HOLD
      step_chk("t5_start", 1'b1, 1'b0, 16'h0, 5'b11000);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, fb[k*W +: W]);
      step_chk("t5_commit", 1'b0, 1'b1, fb[5*W +: W], 5'b01001);
      reset_n_i = 1'b0;
      #2;
      chk("t5_rst_status", 32'(stat()), 32'(0));
      chk_cfg("t5_rst", fz);
      @(negedge clock_i) reset_n_i = 1'b1;
      @(posedge clock_i); #1;
      chk("t5_idle", 32'(stat()), 32'(0));

      // Test 2: backpressure gaps, from a zeroed config
      step_chk("t2_start", 1'b1, 1'b0, 16'h0, 5'b11000);
      for (int k = 0; k < 6; k++) begin
         for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 16'h0);
         chk($sformatf("t2_gap_c0_%0d", k), 32'(coef_0_o), 32'(0));
         chk($sformatf("t2_gap_fm_%0d", k), 32'(f_mode_o), 32'(0));
         if (k < 5) step_chk($sformatf("t2_w%0d", k), 1'b0, 1'b1, fa[k*W +: W], 5'b11000);
         else       step_chk("t2_w5", 1'b0, 1'b1, fa[k*W +: W], 5'b01001);
      end
      chk_cfg("t2_commit", fa);
      step_chk("t2_hold2", 1'b0, 1'b0, 16'h0, 5'b01001);
      step_chk("t2_done", 1'b0, 1'b0, 16'h0, 5'b00100);

      // Test 3: restart mid-frame
      step_chk("t3_start", 1'b1, 1'b0, 16'h0, 5'b11000);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, fa[k*W +: W]);
      step_chk("t3_restart", 1'b1, 1'b1, 16'hFFFF, 5'b11010);
      for (int k = 0; k < 5; k++)
         step_chk($sformatf("t3_w%0d", k), 1'b0, 1'b1, fb[k*W +: W], 5'b11000);
      chk_cfg("t3_pre", fa);
      step_chk("t3_w5", 1'b0, 1'b1, fb[5*W +: W], 5'b01001);
      step(1'b0, 1'b0, 16'h0);
      step_chk("t3_done", 1'b0, 1'b0, 16'h0, 5'b00100);
      chk_cfg("t3_final", fb);

      // Test 4: pad violation
      step_chk("t4_start", 1'b1, 1'b0, 16'h0, 5'b11000);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, fbad[k*W +: W]);
      step_chk("t4_reject", 1'b0, 1'b1, fbad[5*W +: W], 5'b00010);
      step_chk("t4_after", 1'b0, 1'b0, 16'h0, 5'b00000);
      step_chk("t4_after2", 1'b0, 1'b0, 16'h0, 5'b00000);
      chk_cfg("t4_keep", fb);

      // Test 6: HOLD_CYCLES=1, start with valid in IDLE
      bstep_chk("t6_start_valid", 1'b1, 1'b1, 16'hFFFF, 5'b11000);
      for (int k = 0; k < 5; k++)
         bstep_chk($sformatf("t6_w%0d", k), 1'b0, 1'b1, fc[k*W +: W], 5'b11000);
      bstep_chk("t6_w5", 1'b0, 1'b1, fc[5*W +: W], 5'b01001);
      bstep_chk("t6_done", 1'b0, 1'b0, 16'h0, 5'b00100);
      bstep_chk("t6_idle", 1'b0, 1'b0, 16'h0, 5'b00000);
      chk("t6_fm",  32'(b_fm), 32'(fc[0]));
      chk("t6_os",  32'(b_os), 32'(fc[3:1]));
      chk("t6_sat", 32'(b_sat), 32'(fc[4]));
      chk("t6_sh",  32'(b_sh), 32'(fc[10:5]));
      chk("t6_sub", 32'(b_sub), 32'(fc[12]));
      chk("t6_c0",  32'(b_c0), 32'(fc[14 +: NA]));
      chk("t6_c3",  32'(b_c3), 32'(fc[74 +: NA]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ql_dsp_cfg_loader.md
Name: ql_dsp_cfg_loader

Overview:
Loads the static operating-mode and FIR-coefficient configuration of one DSP tile from a 16-bit word-stream interface. Words are assembled in a shadow register and committed atomically to the parallel config outputs, which drive the DSP tile's static-control inputs. During each commit it asserts a hold pulse on the tile's local reset, so the DSP never computes with partially loaded configuration.

Parameters:
NBITS_A, 20, coefficient width; equals the DSP A-operand width.
WORD_W, 16, width of each config word.
HOLD_CYCLES, 2, number of cycles dsp_hold_o stays asserted per commit (must be >=1).
Derived localparams:
- CFG_BITS = 14 + 4*NBITS_A, which is 94 at defaults.
- NWORDS = ceil(CFG_BITS/WORD_W), which is 6 at defaults.

Ports:
clock_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
cfg_start_i  in  1  begin-frame strobe
cfg_valid_i  in  1  cfg_data_i valid
cfg_data_i  in  WORD_W  config word, LSB-first frame order
cfg_ready_o  out  1  loader accepts a word
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse: frame committed and hold released
err_o  out  1  one-cycle pulse: frame aborted or rejected
dsp_hold_o  out  1  local reset to the DSP tile
f_mode_o  out  1  fractured mode
output_select_o  out  3  output select
saturate_enable_o  out  1  saturate enable
shift_right_o  out  6  shift amount
round_o  out  1  round enable
subtract_o  out  1  subtract enable
register_inputs_o  out  1  register-inputs enable
coef_0_o..coef_3_o  out  NBITS_A each  FIR coefficients

Behaviour:
- Frame vector layout, built LSB-first with word k filling bits [k*WORD_W +: WORD_W]:
  - [0] f_mode
  - [3:1] output_select
  - [4] saturate
  - [10:5] shift_right
  - [11] round
  - [12] subtract
  - [13] register_inputs
  - [14 + i*NBITS_A +: NBITS_A] coef_i
  - bits CFG_BITS..NWORDS*WORD_W-1 are pad.
- Reset (reset_n_i=0, asynchronous): state=IDLE; all config outputs, shadow register, word counter, cfg_ready_o, busy_o, done_o, err_o and dsp_hold_o = 0.
- State IDLE:
  - cfg_ready_o=0.
  - cfg_start_i=1 -> LOAD, counter=0, shadow cleared.
  - A cfg_valid_i in the same cycle as cfg_start_i is not accepted.
- State LOAD:
  - cfg_ready_o=1.
  - A word is accepted on every edge where cfg_valid_i & cfg_ready_o; it is written into the shadow slice for the current counter value, then counter increments.
  - cfg_start_i=1 in LOAD (with or without valid): err_o pulses next cycle, counter=0, shadow cleared, state stays LOAD, and the word is not accepted.
  - On acceptance of word NWORDS-1:
    - Pad bits nonzero: reject. err_o pulses, state -> IDLE, outputs unchanged, dsp_hold_o not asserted.
    - Otherwise: at that same edge, config outputs <= shadow (including the final word), dsp_hold_o <= 1, hold counter=0, state -> HOLD.
- State HOLD:
  - cfg_ready_o=0; cfg_start_i is ignored.
  - dsp_hold_o stays 1 for exactly HOLD_CYCLES cycles.
  - On the edge ending the last hold cycle: dsp_hold_o <= 0, state -> IDLE, done_o <= 1 for one cycle.
- Config outputs change only at a commit edge, never mid-frame.
- busy_o is high in LOAD and HOLD.
- Latency: last word accepted at edge N -> outputs updated and hold high from N; hold low and done_o high from N+HOLD_CYCLES.
- Reset mid-LOAD or mid-HOLD: immediate return to reset values; any partial frame is discarded.
- cfg_valid_i is a don't-care outside LOAD; no words are buffered.

Test Plan:
1. Nominal load (defaults).
   - Stimulus: start, then 6 words encoding f_mode=1, output_select=3'b101, shift_right=6'd17, coef_0=20'hABCDE, coef_3=20'h12345, other fields 0, pad 0.
   - Response: outputs match exactly at the 6th-word edge; dsp_hold_o high 2 cycles; done_o one pulse; busy_o low afterwards.
2. Backpressure gaps.
   - Stimulus: same frame with cfg_valid_i low 3 cycles between each word.
   - Response: identical outputs; no output changes before the 6th word.
3. Restart mid-frame.
   - Stimulus: 3 words, then cfg_start_i, then a full 6-word frame with coef_1=20'h00FFF.
   - Response: err_o one pulse after restart; final coef_1=20'h00FFF; no stale bits from the first 3 words.
4. Pad violation.
   - Stimulus: frame whose word 5 has bit 15 (frame bit 95) set.
   - Response: err_o pulse, state IDLE, outputs keep their previous committed values, dsp_hold_o stays 0, no done_o.
5. Async reset during HOLD.
   - Stimulus: reset_n_i low for 1 cycle after commit.
   - Response: all outputs 0 immediately, including dsp_hold_o; a new frame then loads normally.
6. HOLD_CYCLES=1 and start-with-valid.
   - Stimulus: cfg_start_i and cfg_valid_i asserted together in IDLE.
   - Response: that word is not counted; hold lasts exactly 1 cycle.
